rom_sequencer: RTL and testbench

ROM_SEQUENCER -- requirements
Module: rom_sequencer

---
 rtl/rom_sequencer.sv | 116 +++++++++++
 tb/tb_rom_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// rom_sequencer: walks a microcode ROM from prog_start to prog_end and hands
// each instruction to the datapath with a valid/ready handshake.
// ROM is registered, so every instruction costs an ADDR cycle and an ISSUE cycle.
// Optional feature: define SEQ_LOOP_EN to repeat the program loop_cnt extra times.
module rom_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  prog_start,
  input  logic [8:0]  prog_end,
  input  logic [7:0]  loop_cnt,
  output logic [8:0]  rom_addr,
  input  logic [28:0] rom_out,
  output logic [28:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ISSUE, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [8:0] pc_q, pc_d;
  logic [8:0] end_q, end_d;
  logic       hs;
  logic       at_end;
  logic       rewind;

`ifdef SEQ_LOOP_EN
  logic [8:0] beg_q, beg_d;
  logic [7:0] cnt_q, cnt_d;

  assign rewind = (cnt_q != 8'd0);
`else
  // Without looping the repeat count has no consumer.
  logic loop_cnt_unused;

  assign loop_cnt_unused = ^loop_cnt;
  assign rewind          = 1'b0;
`endif

  assign hs     = (state_q == S_ISSUE) && ins_ready;
  assign at_end = (pc_q == end_q);

  // State and program registers, cleared asynchronously on reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      end_q   <= '0;
`ifdef SEQ_LOOP_EN
      beg_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
`ifdef SEQ_LOOP_EN
      beg_q   <= beg_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = S_ISSUE;
      S_ISSUE: if (hs) state_d = (at_end && !rewind) ? S_DONE : S_ADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Program counter / latched program bounds; frozen while a program runs
  always_comb begin
    pc_d  = pc_q;
    end_d = end_q;
`ifdef SEQ_LOOP_EN
    beg_d = beg_q;
    cnt_d = cnt_q;
`endif
    if (state_q == S_IDLE && start) begin
      pc_d  = prog_start;
      end_d = prog_end;
`ifdef SEQ_LOOP_EN
      beg_d = prog_start;
      cnt_d = loop_cnt;
`endif
    end else if (hs) begin
      if (!at_end) begin
        pc_d = pc_q + 9'd1;  // natural 9-bit wrap 511 -> 0
      end
`ifdef SEQ_LOOP_EN
      else if (rewind) begin
        pc_d  = beg_q;
        cnt_d = cnt_q - 8'd1;
      end
`endif
    end
  end

  // Outputs decoded from state; rom_addr sits on pc so ins stays stable in ISSUE
  always_comb begin
    rom_addr  = pc_q;
    ins       = rom_out;
    ins_valid = (state_q == S_ISSUE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: registered ROM model with random contents, and a
// reference that lists the addresses each program must issue, in order.
module tb_rom_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  prog_start = '0;
  logic [8:0]  prog_end = '0;
  logic [7:0]  loop_cnt = '0;
  logic [8:0]  rom_addr;
  logic [28:0] rom_out;
  logic [28:0] ins;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [28:0] rom [512];
  int checks = 0;
  int failures = 0;
  int q_addr[$];
  int q_k[$];
  int exp_q[$];
  int n_done, done_k, n_valid;

  rom_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .prog_start(prog_start),
    .prog_end(prog_end), .loop_cnt(loop_cnt), .rom_addr(rom_addr),
    .rom_out(rom_out), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_out <= rom[rom_addr];

  function automatic int passes(input int l);
`ifdef SEQ_LOOP_EN
    return l + 1;
`else
    return 1;
`endif
  endfunction

  // Reference: walk s..e modulo 512, repeated for every pass
  task automatic build_exp(input int s, input int e, input int l);
    exp_q.delete();
    for (int p = 0; p < passes(l); p++) begin
      int a;
      a = s;
      for (int n = 0; n < 512; n++) begin
        exp_q.push_back(a);
        if (a == e) break;
        a = (a + 1) % 512;
      end
    end
  endtask

  // Runs one program from posedge+1; checks protocol every cycle and logs handshakes
  task automatic run_prog(input int s, input int e, input int l, input int rdy_pct,
                          input int stall_n, input bit noise);
    int stalled;
    int k;
    bit pv, phs;
    logic [8:0]  pa;
    logic [28:0] pi;
    stalled = 0; pv = 0; phs = 0; pa = '0; pi = '0;
    q_addr.delete(); q_k.delete();
    n_done = 0; done_k = -1; n_valid = 0;
    prog_start = s[8:0]; prog_end = e[8:0]; loop_cnt = l[7:0];
    start = 1'b1; ins_ready = 1'b0;
    @(posedge clk); #1;
    for (k = 1; k <= 2000; k++) begin
      start = noise && (done || $urandom_range(3) == 0);
      prog_start = 9'($urandom); prog_end = 9'($urandom); loop_cnt = 8'($urandom);
      if (ins_valid && stalled < stall_n) begin
        ins_ready = 1'b0; stalled++;
      end else ins_ready = ($urandom_range(99) < rdy_pct);
      if (pv && !phs) begin
        checks++;
        if (ins_valid !== 1'b1 || rom_addr !== pa || ins !== pi) begin
          failures++;
          $display("FAIL hold k=%0d got valid=%b addr=%0d ins=%h want valid=1 addr=%0d ins=%h",
                   k, ins_valid, rom_addr, ins, pa, pi);
        end
      end
      if (ins_valid) begin
        n_valid++; checks++;
        if (ins !== rom[rom_addr]) begin
          failures++;
          $display("FAIL ins_data addr=%0d got %h want %h", rom_addr, ins, rom[rom_addr]);
        end
      end
      if (ins_valid && ins_ready) begin
        q_addr.push_back(int'(rom_addr)); q_k.push_back(k);
      end
      if (done) begin n_done++; done_k = k; end
      pv = ins_valid; phs = ins_valid && ins_ready; pa = rom_addr; pi = ins;
      if (!busy) break;
      @(posedge clk); #1;
    end
    start = 1'b0; ins_ready = 1'b0;
    if (k > 2000) begin
      checks++; failures++;
      $display("FAIL timeout prog %0d..%0d busy=%b want busy=0 within 2000 cycles", s, e, busy);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ins_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_after got busy=%b done=%b valid=%b want 0 0 0", busy, done, ins_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== 9'd0 || ins_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset got addr=%0d valid=%b busy=%b done=%b want 0 0 0 0",
               rom_addr, ins_valid, busy, done);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int want_k[4] = '{2, 4, 6, 8};
    run_prog(0, 3, 0, 100, 0, 0);
    build_exp(0, 3, 0);
    checks++;
    if (q_addr.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_len got %0d want %0d", q_addr.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < q_addr.size()) begin
      checks++;
      if (q_addr[i] != exp_q[i]) begin
        failures++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, q_addr[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) if (i < q_k.size()) begin
      checks++;
      if (q_k[i] != want_k[i]) begin
        failures++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, q_k[i], want_k[i]);
      end
    end
    checks++;
    if (n_done != 1 || done_k != 9 || n_valid != 4) begin
      failures++;
      $display("FAIL basic_done got n_done=%0d at %0d valid_cycles=%0d want 1 at 9 valid_cycles=4",
               n_done, done_k, n_valid);
    end
  endtask

  task automatic test_stall();
    run_prog(424, 424, 0, 100, 5, 0);
    build_exp(424, 424, 0);
    checks++;
    if (q_addr.size() != exp_q.size() || (q_addr.size() > 0 && q_addr[0] != exp_q[0])) begin
      failures++;
      $display("FAIL stall_addr got n=%0d first=%0d want n=%0d first=424",
               q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : -1, exp_q.size());
    end
    checks++;
    if (n_done != 1 || n_valid < 6) begin
      failures++;
      $display("FAIL stall_done got n_done=%0d valid_cycles=%0d want 1 and >=6", n_done, n_valid);
    end
  endtask

  task automatic test_wrap_loop(input int s, input int e, input int l, input bit noise);
    run_prog(s, e, l, 70, 0, noise);
    build_exp(s, e, l);
    checks++;
    if (q_addr.size() != exp_q.size()) begin
      failures++;
      $display("FAIL seq_len %0d..%0d x%0d got %0d want %0d", s, e, l, q_addr.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < q_addr.size()) begin
      checks++;
      if (q_addr[i] != exp_q[i]) begin
        failures++; $display("FAIL seq_addr[%0d] got %0d want %0d", i, q_addr[i], exp_q[i]);
      end
    end
    checks++;
    if (n_done != 1) begin
      failures++; $display("FAIL seq_done got %0d pulses want 1", n_done);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    prog_start = 9'd0; prog_end = 9'd20; loop_cnt = 8'd0; start = 1'b1; ins_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 60; n++) begin
      if (ins_valid && rom_addr == 9'd5) break;
      @(posedge clk); #1;
    end
    checks++;
    if (n == 60) begin
      failures++; $display("FAIL rst_mid_reach got addr=%0d want ISSUE at 5", rom_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 9'd0 || ins_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got addr=%0d valid=%b busy=%b done=%b want 0 0 0 0",
               rom_addr, ins_valid, busy, done);
    end
    ins_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    test_wrap_loop(100, 102, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int s, e, l;
      s = $urandom_range(511);
      e = (s + $urandom_range(5)) % 512;
      l = $urandom_range(3);
      test_wrap_loop(s, e, l, bit'($urandom_range(1)));
    end
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 29'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_wrap_loop(510, 1, 0, 0);
    test_reset_mid();
    test_wrap_loop(4, 5, 2, 0);
    test_wrap_loop(7, 9, 1, 1);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
